mux2_arbiter: RTL and testbench

- Round-robin arbiter that shares one 2-to-1 multiplexed output channel between two requesters, A and B.
- It owns the mux select line. It grants one requester at a time and holds the grant for a whole packet, up to a burst limit.
- It sits between two producer blocks and a single downstream consumer that uses a valid/ready handshake.

---
 rtl/mux2_arbiter.sv | 66 ++++++
 tb/tb_mux2_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin arbiter that owns the select of a 2:1 channel mux and holds each grant for a packet, capped at MAX_BURST words
// Ports: clk, n_reset (async active-low); requester A (req_a, a_data, a_last) and B (req_b, b_data, b_last);
//        consumer out_ready; shared channel out_valid/out_data/out_last; sel (0 = A, 1 = B); gnt_a, gnt_b; burst_cnt
module mux2_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              req_a,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  input  logic              req_b,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              sel,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic [3:0]        burst_cnt
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  localparam logic [3:0] CAP = 4'(MAX_BURST - 1);
  state_t state, state_nx, idle_pick, other;
  logic last_served;
  logic xfer, req_own, req_other, rel;
  assign gnt_a     = state == OWN_A;
  assign gnt_b     = state == OWN_B;
  assign out_data  = sel ? b_data : a_data;
  assign out_last  = sel ? b_last : a_last;
  assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);
  assign xfer      = out_valid & out_ready;
  always_comb begin
    req_own   = gnt_b ? req_b : req_a;
    req_other = gnt_b ? req_a : req_b;
    other     = gnt_b ? OWN_A : OWN_B;
    // last_served = 1 means B went last, so A wins a tie
    idle_pick = (req_a & req_b) ? (last_served ? OWN_A : OWN_B) :
                req_a ? OWN_A : req_b ? OWN_B : IDLE;
    // packet end, burst cap, or a grant abandoned before its first word
    rel       = (state != IDLE) & ((xfer & (out_last | burst_cnt == CAP)) |
                                   (~req_own & burst_cnt == 4'd0));
    state_nx  = (state == IDLE) ? idle_pick :
                rel ? (req_other ? other : IDLE) : state;
  end
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= IDLE;
      sel         <= 1'b0;
      last_served <= 1'b1;
      burst_cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      sel   <= (state_nx == OWN_B) ? 1'b1 : (state_nx == OWN_A) ? 1'b0 : sel;
      if (rel) begin
        last_served <= gnt_b;
        burst_cnt   <= 4'd0;
      end else if (xfer) begin
        burst_cnt <= burst_cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_mux2_arbiter.sv
// tb_mux2_arbiter: table-driven per-cycle checks plus a transfer scoreboard for mux2_arbiter
module tb_mux2_arbiter;
  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       req_a = 1'b0, a_last = 1'b0, req_b = 1'b0, b_last = 1'b0, out_ready = 1'b0;
  logic [7:0] a_data = '0, b_data = '0;
  logic       out_valid, out_last, sel, gnt_a, gnt_b;
  logic [7:0] out_data;
  logic [3:0] burst_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] sb[$];

  mux2_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .n_reset(n_reset),
    .req_a(req_a), .a_data(a_data), .a_last(a_last),
    .req_b(req_b), .b_data(b_data), .b_last(b_last),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .sel(sel), .gnt_a(gnt_a), .gnt_b(gnt_b), .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ra; logic [7:0] ad; logic al;
    logic rb; logic [7:0] bd; logic bl;
    logic rdy;
    logic ga, gb, sl, ov; logic [7:0] od; logic [3:0] bc;
  } vec_t;
  vec_t v[$];

  function automatic vec_t mk(logic ra, logic [7:0] ad, logic al, logic rb, logic [7:0] bd, logic bl,
                              logic rdy, logic ga, logic gb, logic sl, logic ov, logic [7:0] od, logic [3:0] bc);
    vec_t r;
    r.ra = ra; r.ad = ad; r.al = al; r.rb = rb; r.bd = bd; r.bl = bl; r.rdy = rdy;
    r.ga = ga; r.gb = gb; r.sl = sl; r.ov = ov; r.od = od; r.bc = bc;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (n_reset && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_xfer", {out_last, out_data}, 9'h1ff);
      else begin
        logic [8:0] e;
        e = sb.pop_front();
        chk("sb_xfer", {out_last, out_data}, e);
      end
    end
  end

  initial begin
    v.push_back(mk(1,8'hAA,1,1,8'hBB,1,1, 0,0,0,0,8'h00,0));
    v.push_back(mk(1,8'hAA,1,1,8'hBB,1,1, 1,0,0,1,8'hAA,0));
    v.push_back(mk(1,8'hAA,1,1,8'hBB,1,1, 0,1,1,1,8'hBB,0));
    v.push_back(mk(1,8'hA1,1,1,8'hBB,1,1, 1,0,0,1,8'hA1,0));
    v.push_back(mk(0,8'hA1,1,1,8'hB1,1,1, 0,1,1,1,8'hB1,0));
    v.push_back(mk(0,8'h00,0,0,8'h00,0,1, 0,0,1,0,8'h00,0));
    v.push_back(mk(1,8'h11,0,0,8'h00,0,1, 0,0,1,0,8'h00,0));
    v.push_back(mk(1,8'h11,0,0,8'h00,0,1, 1,0,0,1,8'h11,0));
    v.push_back(mk(1,8'h22,0,0,8'h00,0,1, 1,0,0,1,8'h22,1));
    v.push_back(mk(1,8'h33,1,0,8'h00,0,1, 1,0,0,1,8'h33,2));
    v.push_back(mk(0,8'h00,0,0,8'h00,0,1, 0,0,0,0,8'h00,0));
    v.push_back(mk(1,8'h01,0,0,8'h00,0,1, 0,0,0,0,8'h00,0));
    v.push_back(mk(1,8'h01,0,1,8'hC1,1,1, 1,0,0,1,8'h01,0));
    v.push_back(mk(1,8'h02,0,1,8'hC1,1,1, 1,0,0,1,8'h02,1));
    v.push_back(mk(1,8'h03,0,1,8'hC1,1,1, 1,0,0,1,8'h03,2));
    v.push_back(mk(1,8'h04,0,1,8'hC1,1,1, 1,0,0,1,8'h04,3));
    v.push_back(mk(1,8'h05,0,1,8'hC1,1,1, 0,1,1,1,8'hC1,0));
    v.push_back(mk(1,8'h05,0,0,8'h00,0,1, 1,0,0,1,8'h05,0));
    v.push_back(mk(1,8'h06,1,0,8'h00,0,0, 1,0,0,1,8'h06,1));
    v.push_back(mk(1,8'h06,1,0,8'h00,0,0, 1,0,0,1,8'h06,1));
    v.push_back(mk(1,8'h06,1,0,8'h00,0,0, 1,0,0,1,8'h06,1));
    v.push_back(mk(1,8'h06,1,0,8'h00,0,1, 1,0,0,1,8'h06,1));
    v.push_back(mk(1,8'h07,0,0,8'h00,0,1, 0,0,0,0,8'h00,0));
    v.push_back(mk(0,8'h07,0,1,8'hD1,0,1, 1,0,0,0,8'h00,0));
    v.push_back(mk(0,8'h00,0,1,8'hD1,0,1, 0,1,1,1,8'hD1,0));
    v.push_back(mk(0,8'h00,0,0,8'hD1,0,1, 0,1,1,0,8'h00,1));
    v.push_back(mk(0,8'h00,0,1,8'hD2,1,1, 0,1,1,1,8'hD2,1));
    v.push_back(mk(0,8'h00,0,0,8'h00,0,1, 0,0,1,0,8'h00,0));
    v.push_back(mk(0,8'h00,0,1,8'hE1,0,1, 0,0,1,0,8'h00,0));
    v.push_back(mk(0,8'h00,0,1,8'hE1,0,1, 0,1,1,1,8'hE1,0));
    v.push_back(mk(0,8'h00,0,1,8'hE2,0,1, 0,1,1,1,8'hE2,1));

    req_a = 1'b1; req_b = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt_a", gnt_a, 0);
    chk("rst_gnt_b", gnt_b, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_sel", sel, 0);
    chk("rst_burst", burst_cnt, 0);
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    foreach (v[i]) begin
      req_a = v[i].ra; a_data = v[i].ad; a_last = v[i].al;
      req_b = v[i].rb; b_data = v[i].bd; b_last = v[i].bl;
      out_ready = v[i].rdy;
      if (v[i].ov && v[i].rdy) sb.push_back({v[i].sl ? v[i].bl : v[i].al, v[i].od});
      @(negedge clk);
      chk($sformatf("v%0d_gnt_a", i), gnt_a, v[i].ga);
      chk($sformatf("v%0d_gnt_b", i), gnt_b, v[i].gb);
      chk($sformatf("v%0d_sel", i), sel, v[i].sl);
      chk($sformatf("v%0d_valid", i), out_valid, v[i].ov);
      chk($sformatf("v%0d_burst", i), burst_cnt, v[i].bc);
      if (v[i].ov) chk($sformatf("v%0d_data", i), out_data, v[i].od);
      @(posedge clk);
      #1;
    end

    req_a = 1'b1; a_data = 8'hF0; a_last = 1'b1;
    req_b = 1'b1; b_data = 8'hE3; b_last = 1'b0;
    n_reset = 1'b0;
    #1;
    chk("midrst_gnt_a", gnt_a, 0);
    chk("midrst_gnt_b", gnt_b, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_sel", sel, 0);
    chk("midrst_burst", burst_cnt, 0);
    @(negedge clk);
    n_reset = 1'b1;
    sb.push_back({1'b1, 8'hF0});
    @(posedge clk);
    #1;
    chk("post_rst_gnt_a", gnt_a, 1);
    chk("post_rst_gnt_b", gnt_b, 0);
    chk("post_rst_sel", sel, 0);
    @(posedge clk);
    #1;
    req_a = 1'b0; req_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("end_idle_gnt_b", gnt_b, 0);
    chk("sb_leftover", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
